data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256; number of 32-bit words of backing storage.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2; wait states inserted between request accept and response, range 0..15.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  1  initiator request strobe.
REQ-006 SHALL have port addr  input  32  byte address of request.
REQ-007 SHALL have port wren  input  4  byte write enables; bit n covers wdata[8n+7:8n]; all-zero means read.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port ack  output  1  one-cycle response strobe.
REQ-010 SHALL have port rdata  output  32  read data, valid with ack.
REQ-011 SHALL have port err  output  1  error flag, valid with ack.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-014 SHALL accept a request only in IDLE with req=1, capturing addr, wren, wdata into internal registers that same edge.
REQ-015 SHALL transition on accept IDLE->WAIT with wait counter loaded to WAIT_CYCLES, or IDLE->RESP directly when WAIT_CYCLES=0.
REQ-016 SHALL decrement the wait counter each cycle in WAIT and move WAIT->RESP when the counter reaches 1.
REQ-017 SHALL assert ack for exactly one cycle in RESP, WAIT_CYCLES+1 cycles after the accept edge, then return RESP->IDLE unconditionally.
REQ-018 SHALL ignore req and input changes while in WAIT or RESP; captured values only are used.
REQ-019 SHALL not accept a request on the edge leaving RESP; req held high is accepted on the following edge (back-to-back throughput one access per WAIT_CYCLES+2 cycles).
REQ-020 SHALL flag err=1 with ack when captured addr[1:0]!=0 (misaligned) or addr[31:2]>=DEPTH_WORDS (out of range).
REQ-021 SHALL perform no storage write on an erroring access, and SHALL drive rdata=0 on it.
REQ-022 SHALL commit a valid write on the RESP edge, updating only bytes whose wren bit is set; other bytes unchanged.
REQ-023 SHALL, for a valid read (wren=0), drive rdata with the word at addr[31:2] during the ack cycle.
REQ-024 SHALL drive rdata=0 on every cycle other than a valid read ack, including write acks.
REQ-025 SHALL drive err=0 whenever ack=0.
REQ-026 SHALL, on a read following a write to the same word, return the newly written data.

Reset
REQ-027 SHALL on rst=0 force FSM to IDLE, wait counter to 0, ack=0, err=0, busy=0, rdata=0, captured registers to 0, immediately and independent of clk.
REQ-028 SHALL discard any pending access on reset mid-operation; no write commits, no ack follows.
REQ-029 SHALL not clear storage contents on reset.
REQ-030 SHALL accept a request on the first rising edge after rst deasserts.

Structure
REQ-031 SHALL place FSM state encoding (IDLE=0, WAIT=1, RESP=2) and the default parameter values in shared package dmem_pkg.
REQ-032 SHALL implement storage as sub-module dmem_word_array (synchronous byte-enable write, combinational read by word index).

Verification
REQ-033 Write then read: write addr=0x10 wdata=0xDEADBEEF wren=0xF, then read addr=0x10 -> each ack exactly 3 cycles after accept, read rdata=0xDEADBEEF, err=0.
REQ-034 Byte enables: word 0x20 holds 0x11223344, write wdata=0xAABBCCDD wren=0x5 -> read returns 0x11BB33DD.
REQ-035 Errors: read addr=0x2 and read addr=0x400 (DEPTH 256) -> ack with err=1, rdata=0; subsequent read of word 0 unchanged.
REQ-036 Back-to-back: req held high for 4 reads -> acks spaced exactly 4 cycles apart, busy low only on accept cycles.
REQ-037 Reset mid-op: write addr=0x8 wdata=0x12345678, assert rst in WAIT -> no ack, busy=0 immediately, read addr=0x8 returns prior value.
REQ-038 WAIT_CYCLES=0 build: read addr=0x0 -> ack on the cycle after accept, FSM never enters WAIT.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data memory responder.
// Holds the FSM state encoding and the default sizing parameters.
package dmem_pkg;

    localparam int DEPTH_WORDS_DEF = 256;
    localparam int WAIT_CYCLES_DEF = 2;
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_word_array.sv
// Word-organised storage with per-byte write enables.
// Ports: clk; we/be/idx/wdata write one word (bytes selected by be)
// on the rising edge; rdata is the word at idx, combinationally.
module dmem_word_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW          = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // No reset: contents survive a responder reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Request/ack data memory slave with a fixed number of wait states.
// Ports: clk, rst (async, active-low); req/addr/wren/wdata request;
// ack/rdata/err response (one-cycle strobe); busy = FSM not idle.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic [3:0]  wren,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);
    localparam logic [31:0] DEPTH_U = 32'(DEPTH_WORDS);

    state_t                state;
    state_t                state_n;
    logic [WAIT_CNT_W-1:0] cnt;
    logic [WAIT_CNT_W-1:0] cnt_n;
    logic [31:0]           addr_q;
    logic [3:0]            wren_q;
    logic [31:0]           wdata_q;
    logic                  accept;
    logic                  in_resp;
    logic                  bad;
    logic                  is_read;
    logic [31:0]           mem_rdata;

    assign accept = (state == IDLE) && req;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                // Leave on a count of 1; <2 also guards a stray 0.
                if (cnt < WAIT_CNT_W'(2)) begin
                    state_n = RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wren_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q  <= addr;
                wren_q  <= wren;
                wdata_q <= wdata;
            end
        end
    end

    assign in_resp = (state == RESP);
    assign is_read = (wren_q == 4'b0000);
    assign bad     = (addr_q[1:0] != 2'b00)
                   || ({2'b00, addr_q[31:2]} >= DEPTH_U);

    dmem_word_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (in_resp && !bad && !is_read),
        .be    (wren_q),
        .idx   (addr_q[AW+1:2]),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    assign ack   = in_resp;
    assign err   = in_resp && bad;
    assign busy  = (state != IDLE);
    assign rdata = (in_resp && !bad && is_read) ? mem_rdata : 32'h0;

endmodule
